demux_1_4_stream: RTL
=====================

Name: demux_1_4_stream

Overview:
- Stream demultiplexer: the inverse of the team's 4:1 data muxes.
- Accepts one valid/ready input stream of WIDTH-bit words, each tagged with a 2-bit destination select, and routes every word to one of four output channels.
- An optional broadcast flag copies a word to all four channels.
- Each channel has its own 2-entry FIFO, so a stalled consumer does not block the others, and in_ready is a registered-only function of FIFO occupancy (no combinational ready path from any consumer).

Parameters:
WIDTH, 4, data word width in bits (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  producer has a word on in_data
in_ready  output  1  block accepts the word this cycle
in_data  input  WIDTH  input word
in_sel  input  2  destination channel 0..3, ignored when in_bcast=1
in_bcast  input  1  write word to all four channels
out_valid  output  4  bit i: channel i head word valid
out_ready  input  4  bit i: consumer i takes head word
out_data0  output  WIDTH  channel 0 head word
out_data1  output  WIDTH  channel 1 head word
out_data2  output  WIDTH  channel 2 head word
out_data3  output  WIDTH  channel 3 head word

Behaviour:
- Reset (async, rst=1): all four FIFOs empty (count=0, pointers 0); out_valid=4'b0000; in_ready=1; out_dataN=0. Reset mid-transfer discards all buffered words; no partial state survives.
- Per-channel FIFO: depth 2, count in 0..2, 1-bit read/write pointers that wrap 1->0. out_valid[i] = (count_i != 0). out_data_i = entry at rd_ptr_i, and must be 0 when empty.
- Accept condition (input handshake): in_fire = in_valid & in_ready.
  - Unicast (in_bcast=0): in_ready = (count[in_sel] < 2).
  - Broadcast (in_bcast=1): in_ready = all four counts < 2.
  - in_ready depends only on registered counts and the in_sel/in_bcast inputs, never on out_ready.
- Write: on in_fire the word is written at wr_ptr of the target channel (all four for broadcast) and wr_ptr increments.
- Read: out_fire_i = out_valid[i] & out_ready[i]; on out_fire_i rd_ptr_i increments.
- Count update per channel: +1 on write only, -1 on read only, unchanged on simultaneous write and read. A simultaneous read and write at count=1 keeps count=1, with the new word at the head next cycle.
- Full is evaluated on the pre-edge count. A channel at count=2 with out_ready=1 does NOT accept a write in the same cycle: no bypass, and in_ready=0 that cycle.
- Latency: a word accepted at edge k appears on out_valid/out_data at edge k (visible the cycle after acceptance), i.e. one cycle from in_fire to out_valid. Throughput is one word per cycle per channel when the consumer keeps out_ready=1.
- Ordering: words to the same channel leave in acceptance order. There is no ordering guarantee across channels.
- in_valid=0: no write, regardless of in_sel/in_bcast.
- Producer rule: in_data/in_sel/in_bcast must stay stable while in_valid=1 and in_ready=0. The bench checks this; the RTL does not.
- Broadcast is all-or-nothing: a word is never written to a subset of channels.

Test Plan:
- Reset then idle: rst pulse mid-cycle (async) -> out_valid=0000, in_ready=1 immediately, out_dataN=0.
- Unicast routing: send 0x3 sel=0, 0x5 sel=1, 0xA sel=2, 0xC sel=3 back-to-back, all out_ready=1 -> each channel shows its word exactly once, one cycle after acceptance, and no other channel asserts valid.
- Backpressure/full: out_ready[2]=0; send 0x1, 0x2, 0x3 to sel=2 -> first two accepted, in_ready=0 on the third. Raise out_ready[2] -> 0x1 then 0x2 drain, 0x3 is accepted the cycle after count drops to 1, and order is 1, 2, 3.
- Isolation: channel 1 full and stalled; send 0x7 to sel=3 -> accepted immediately, and channel 1 contents are unchanged.
- Broadcast: all empty, in_bcast=1, data 0x9 -> out_valid=1111 next cycle, all out_data=0x9. With channel 0 full, a broadcast gives in_ready=0 and no channel is written.
- Simultaneous read/write: channel 0 count=1 holding 0x4, out_ready[0]=1, send 0xB sel=0 -> count stays 1, head is 0xB next cycle. Assert rst while channels hold data -> everything is cleared and the next word is routed normally.

Source files
------------

// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream
//   Routes one valid/ready stream of WIDTH-bit words to four output channels.
//   Each word carries a 2-bit destination select; a broadcast flag copies the
//   word to all four channels at once (all-or-nothing). Every channel owns a
//   2-entry FIFO, so one stalled consumer never blocks traffic to the others.
//   in_ready is derived only from registered FIFO counts plus in_sel/in_bcast;
//   there is no combinational path from any out_ready to in_ready.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high
//   in_valid   producer has a word on in_data
//   in_ready   block accepts the word this cycle
//   in_data    input word
//   in_sel     destination channel 0..3 (ignored when in_bcast=1)
//   in_bcast   write word to all four channels
//   out_valid  bit i: channel i head word valid
//   out_ready  bit i: consumer i takes head word
//   out_dataN  channel N head word (0 when channel N is empty)

module demux_1_4_stream #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_bcast,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3
);

  logic [3:0]       not_full;
  logic [3:0]       wr_en;
  logic [3:0]       rd_en;
  logic             in_fire;
  logic [WIDTH-1:0] head [4];

  // Full is judged on the pre-edge count only: a full channel being drained
  // this cycle still refuses the incoming word (no bypass).
  always_comb begin
    in_ready = 1'b0;
    if (in_bcast) in_ready = &not_full;
    else          in_ready = not_full[in_sel];
  end

  assign in_fire = in_valid & in_ready;
  assign rd_en   = out_valid & out_ready;

  for (genvar ch = 0; ch < 4; ch++) begin : g_chan
    logic [WIDTH-1:0] mem [2];
    logic [1:0]       count;
    logic             wr_ptr;
    logic             rd_ptr;

    assign not_full[ch]  = (count != 2'd2);
    assign wr_en[ch]     = in_fire & (in_bcast | (in_sel == 2'(ch)));
    assign out_valid[ch] = (count != 2'd0);
    assign head[ch]      = (count != 2'd0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        mem[0] <= '0;
        mem[1] <= '0;
      end else begin
        if (wr_en[ch]) begin
          mem[wr_ptr] <= in_data;
          wr_ptr      <= ~wr_ptr;
        end
        if (rd_en[ch]) begin
          rd_ptr <= ~rd_ptr;
        end
        // Simultaneous read and write leaves the occupancy unchanged.
        case ({wr_en[ch], rd_en[ch]})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  assign out_data0 = head[0];
  assign out_data1 = head[1];
  assign out_data2 = head[2];
  assign out_data3 = head[3];

endmodule
